atsc_viterbi_lane_dispatch: RTL and testbench
=============================================

// Module: atsc_viterbi_lane_dispatch
// PURPOSE
// Packet dispatcher/collector for NUM_LANES parallel HLS Viterbi decoder lanes. Sits between axi_wrapper
// (m_axis_data / s_axis_data) and the decoder instances inside the Viterbi NoC block.
// Whole input packets go round-robin to enabled lanes. Outputs are re-collected in original order, with
// each packet's CHDR header (tuser) carried alongside, so downstream cvita_hdr_modify sees in-order headers.
// PARAMETERS
// NUM_LANES   4    number of decoder lanes (1..8)
// WIDTH       32   AXI-stream data width per lane
// HDR_WIDTH   128  tuser (CHDR header) width
// ORD_AW      4    log2 depth of order FIFO; holds in-flight packets
// PORTS
// ce_clk          in   1                    clock
// ce_rst          in   1                    synchronous active-high reset
// lane_en         in   NUM_LANES            lane enable mask; sampled only at packet start
// clear_cnt       in   1                    1-cycle strobe; zero pkt_in_cnt/pkt_out_cnt
// in_tdata        in   WIDTH                input stream from axi_wrapper
// in_tuser        in   HDR_WIDTH            input header; valid on first beat of packet
// in_tlast        in   1                    last beat of input packet
// in_tvalid       in   1                    input valid
// in_tready       out  1                    input ready
// lane_i_tdata    out  NUM_LANES*WIDTH      to lanes; lane k at [k*WIDTH +: WIDTH]
// lane_i_tlast    out  NUM_LANES            last beat to lane k
// lane_i_tvalid   out  NUM_LANES            valid to lane k
// lane_i_tready   in   NUM_LANES            ready from lane k
// lane_o_tdata    in   NUM_LANES*WIDTH      from lanes
// lane_o_tlast    in   NUM_LANES            last beat from lane k
// lane_o_tvalid   in   NUM_LANES            valid from lane k
// lane_o_tready   out  NUM_LANES            ready to lane k
// out_tdata       out  WIDTH                collected output
// out_tuser       out  HDR_WIDTH            header of packet being output
// out_tlast       out  1                    last beat of output packet
// out_tvalid      out  1                    output valid
// out_tready      in   1                    output ready
// pkt_in_cnt      out  32                   packets dispatched (wraps)
// pkt_out_cnt     out  32                   packets collected (wraps)
// inflight        out  ORD_AW+1             order FIFO occupancy
// BEHAVIOUR
// - Reset: d_ptr=0, mid_pkt=0, order FIFO empty, counters=0, inflight=0.
//   All tvalid/tready outputs 0 while ce_rst is high.
// - Dispatch FSM has two states, IDLE (mid_pkt=0) and BUSY (mid_pkt=1).
//   * IDLE: cur = first lane with lane_en set, searching from d_ptr upward and wrapping.
//     If lane_en==0, or the order FIFO is full: in_tready=0 and no lane valid.
//   * First accepted beat: push {cur, in_tuser} to the order FIFO, latch cur into sel, go BUSY.
//   * BUSY: lanes route to sel. lane_en changes and FIFO state are ignored until tlast.
//   * Accepted tlast: d_ptr = sel+1 mod NUM_LANES; pkt_in_cnt++; go IDLE.
//     A single-beat packet pushes and completes in the same cycle.
// - Routing is combinational, zero latency, no data register:
//   lane_i_tvalid[k] = in_tvalid & (k==route) & ok; in_tready = lane_i_tready[route] & ok.
//   lane_i_tdata is broadcast to all lanes.
// - Collector: head entry {hl, hh}.
//   out_tvalid = !empty & lane_o_tvalid[hl]; lane_o_tready[k] = (k==hl) & !empty & out_tready.
//   out_tuser = hh, stable for the whole packet. Accepted out tlast pops the entry and increments pkt_out_cnt.
//   Lanes other than hl are back-pressured, which guarantees output order equals input order.
// - FIFO full/pop: "full" is the registered count. A pop in the same cycle does not permit a push.
//   An empty FIFO with push and pop in the same cycle is impossible: pop needs !empty.
// - Counters: 32-bit modulo wrap.
//   clear_cnt zeroes both counters. If clear_cnt coincides with an increment, the clear wins (result 0).
// - Reset mid-packet discards pointers and FIFO contents. The caller must reset the lanes concurrently.
// - NUM_LANES=1 degenerates to pass-through with header carry.
// TESTING
// 1 NUM_LANES=4, lane_en=4'hF, 8 packets of 16 beats (tuser=pkt#) -> lanes 0,1,2,3,0,1,2,3 each get 2;
//   out order pkt# 0..7, pkt_in_cnt=pkt_out_cnt=8.
// 2 Lane 0 model delays 100 cycles, others 5 -> no pkt1..3 beat appears before pkt0 tlast;
//   out_tuser matches each packet.
// 3 lane_en=4'b0101, toggled to 4'b0010 mid-packet -> current packet completes on its lane;
//   the next packet goes to lane 1.
// 4 ORD_AW=2, out_tready=0, send 5 packets -> 4 accepted, inflight=4, in_tready=0 at 5th start;
//   release -> all 5 out in order.
// 5 Single-beat packets back-to-back with random in/out stalls -> no loss/duplication, data scoreboard passes.
// 6 Assert ce_rst mid-packet, then clear_cnt during tlast -> all outputs 0 after reset, counters read 0.

Source files
------------

// File: rtl/atsc_viterbi_lane_dispatch.sv
// Round-robin packet dispatcher/collector for parallel Viterbi decoder lanes.
// Each packet goes whole to one lane; outputs are re-collected in input order with the header carried alongside.
module atsc_viterbi_lane_dispatch #(
  parameter int NUM_LANES = 4,
  parameter int WIDTH     = 32,
  parameter int HDR_WIDTH = 128,
  parameter int ORD_AW    = 4
) (
  input  logic                       ce_clk,
  input  logic                       ce_rst,
  input  logic [NUM_LANES-1:0]       lane_en,
  input  logic                       clear_cnt,
  input  logic [WIDTH-1:0]           in_tdata,
  input  logic [HDR_WIDTH-1:0]       in_tuser,
  input  logic                       in_tlast,
  input  logic                       in_tvalid,
  output logic                       in_tready,
  output logic [NUM_LANES*WIDTH-1:0] lane_i_tdata,
  output logic [NUM_LANES-1:0]       lane_i_tlast,
  output logic [NUM_LANES-1:0]       lane_i_tvalid,
  input  logic [NUM_LANES-1:0]       lane_i_tready,
  input  logic [NUM_LANES*WIDTH-1:0] lane_o_tdata,
  input  logic [NUM_LANES-1:0]       lane_o_tlast,
  input  logic [NUM_LANES-1:0]       lane_o_tvalid,
  output logic [NUM_LANES-1:0]       lane_o_tready,
  output logic [WIDTH-1:0]           out_tdata,
  output logic [HDR_WIDTH-1:0]       out_tuser,
  output logic                       out_tlast,
  output logic                       out_tvalid,
  input  logic                       out_tready,
  output logic [31:0]                pkt_in_cnt,
  output logic [31:0]                pkt_out_cnt,
  output logic [ORD_AW:0]            inflight
);

  localparam int LW    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int DEPTH = 1 << ORD_AW;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [LW-1:0]        lane;
    logic [HDR_WIDTH-1:0] hdr;
  } ord_t;

  state_t            state, state_nx;
  logic [LW-1:0]     d_ptr, sel, cur, route;
  ord_t              mem [DEPTH];
  ord_t              head;
  logic [ORD_AW-1:0] wr_ptr, rd_ptr;
  logic [ORD_AW:0]   count;
  logic              full, empty, ok, in_acc, push, pop, done;

  assign full     = (count == (ORD_AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign head     = mem[rd_ptr];
  assign inflight = count;

  // First enabled lane at or after d_ptr, wrapping; scanning downward lets the nearest one win.
  always_comb begin
    int            j;
    logic [LW-1:0] jl;
    // NOTE: combinational blocks use blocking '=' with every output defaulted first, so no latch is inferred;
    // clocked blocks use '<=' only.
    cur = d_ptr;
    j   = 0;
    jl  = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      j = int'(d_ptr) + i;
      if (j >= NUM_LANES) j = j - NUM_LANES;
      jl = LW'(j);
      if (lane_en[jl]) cur = jl;
    end
  end

  // Dispatch: route is frozen to sel while a packet is in progress.
  always_comb begin
    state_nx      = state;
    route         = (state == BUSY) ? sel : cur;
    ok            = !ce_rst && ((state == BUSY) || ((|lane_en) && !full));
    in_tready     = ok && lane_i_tready[route];
    lane_i_tvalid = '0;
    if (ok && in_tvalid) lane_i_tvalid[route] = 1'b1;
    in_acc        = in_tvalid && in_tready;
    push          = in_acc && (state == IDLE);
    done          = in_acc && in_tlast;
    if (done)      state_nx = IDLE;
    else if (push) state_nx = BUSY;
  end

  assign lane_i_tdata = {NUM_LANES{in_tdata}};
  assign lane_i_tlast = {NUM_LANES{in_tlast}};

  // Collector: only the lane holding the oldest in-flight packet may drain.
  always_comb begin
    lane_o_tready = '0;
    out_tvalid    = 1'b0;
    if (!empty && !ce_rst) begin
      out_tvalid                = lane_o_tvalid[head.lane];
      lane_o_tready[head.lane]  = out_tready;
    end
  end

  assign out_tdata = lane_o_tdata[int'(head.lane)*WIDTH +: WIDTH];
  assign out_tlast = lane_o_tlast[head.lane];
  assign out_tuser = head.hdr;
  assign pop       = out_tvalid && out_tready && out_tlast;

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      state       <= IDLE;
      d_ptr       <= '0;
      sel         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pkt_in_cnt  <= '0;
      pkt_out_cnt <= '0;
    end else begin
      state <= state_nx;
      if (push) begin
        sel    <= cur;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (done) d_ptr <= (route == LW'(NUM_LANES - 1)) ? '0 : route + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (clear_cnt) begin
        pkt_in_cnt  <= '0;
        pkt_out_cnt <= '0;
      end else begin
        if (done) pkt_in_cnt  <= pkt_in_cnt + 1'b1;
        if (pop)  pkt_out_cnt <= pkt_out_cnt + 1'b1;
      end
    end
  end

  // NOTE: the order storage is deliberately not reset; the pointers and count define validity,
  // and leaving the array out of reset lets it map onto plain RAM.
  always_ff @(posedge ce_clk) begin
    if (push) mem[wr_ptr] <= '{lane: cur, hdr: in_tuser};
  end

endmodule

// File: tb/tb_atsc_viterbi_lane_dispatch.sv
// Self-checking bench: lane models with latency queues, a packet-order scoreboard and per-cycle handshake checks.
module tb_atsc_viterbi_lane_dispatch;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int H     = 128;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic            clk = 1'b0;
  logic            ce_rst;
  logic [N-1:0]    lane_en;
  logic            clear_cnt;
  logic [W-1:0]    in_tdata;
  logic [H-1:0]    in_tuser;
  logic            in_tlast, in_tvalid, in_tready;
  logic [N*W-1:0]  lane_i_tdata;
  logic [N-1:0]    lane_i_tlast, lane_i_tvalid, lane_i_tready;
  logic [N*W-1:0]  lane_o_tdata;
  logic [N-1:0]    lane_o_tlast, lane_o_tvalid, lane_o_tready;
  logic [W-1:0]    out_tdata;
  logic [H-1:0]    out_tuser;
  logic            out_tlast, out_tvalid, out_tready;
  logic [31:0]     pkt_in_cnt, pkt_out_cnt;
  logic [AW:0]     inflight;

  always #5 clk = ~clk;

  atsc_viterbi_lane_dispatch #(.NUM_LANES(N), .WIDTH(W), .HDR_WIDTH(H), .ORD_AW(AW)) dut (
    .ce_clk(clk), .ce_rst(ce_rst), .lane_en(lane_en), .clear_cnt(clear_cnt),
    .in_tdata(in_tdata), .in_tuser(in_tuser), .in_tlast(in_tlast), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .lane_i_tdata(lane_i_tdata), .lane_i_tlast(lane_i_tlast), .lane_i_tvalid(lane_i_tvalid), .lane_i_tready(lane_i_tready),
    .lane_o_tdata(lane_o_tdata), .lane_o_tlast(lane_o_tlast), .lane_o_tvalid(lane_o_tvalid), .lane_o_tready(lane_o_tready),
    .out_tdata(out_tdata), .out_tuser(out_tuser), .out_tlast(out_tlast), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .pkt_in_cnt(pkt_in_cnt), .pkt_out_cnt(pkt_out_cnt), .inflight(inflight)
  );

  typedef struct {
    logic [W-1:0] d;
    bit           l;
  } beat_t;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Lane models: each beat becomes visible lat[k] cycles after the lane accepted it.
  logic [W-1:0] lq_d [N][$];
  bit           lq_l [N][$];
  int           lq_t [N][$];
  int           lat [N];
  int           lane_rdy_pct, out_rdy_pct;

  // Reference model of the dispatcher.
  bit            m_busy;
  int            m_sel, m_dptr;
  int            m_order[$];
  logic [H-1:0]  m_hdr_q[$];
  beat_t         exp_q[$];
  int unsigned   m_in_cnt, m_out_cnt;

  // Observations of DUT lane traffic, used for literal expectations.
  bit obs_busy;
  int obs_first, obs_last;
  int obs_pkts [N];
  int obs_lanes[$];
  int t2_held;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int first_en(input int p, input logic [N-1:0] en);
    for (int i = 0; i < N; i++)
      if (en[(p + i) % N]) return (p + i) % N;
    return p;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_sel = 0; m_dptr = 0;
    m_order.delete(); m_hdr_q.delete(); exp_q.delete();
    m_in_cnt = 0; m_out_cnt = 0;
    obs_busy = 0;
    for (int k = 0; k < N; k++) begin
      lq_d[k].delete(); lq_l[k].delete(); lq_t[k].delete();
    end
  endtask

  // One clock: drive lane models, compare at mid-cycle, advance the model by the expected handshakes.
  task automatic cycle(output bit acc);
    int         r, head;
    bit         ok, exp_rdy, exp_ov;
    logic [N-1:0] exp_lv, exp_lor;
    beat_t      b;
    for (int k = 0; k < N; k++) begin
      if (lq_d[k].size() > 0 && cyc >= lq_t[k][0]) begin
        lane_o_tvalid[k] = 1'b1; lane_o_tdata[k*W +: W] = lq_d[k][0]; lane_o_tlast[k] = lq_l[k][0];
      end else begin
        lane_o_tvalid[k] = 1'b0; lane_o_tdata[k*W +: W] = '0; lane_o_tlast[k] = 1'b0;
      end
      lane_i_tready[k] = (int'($urandom_range(99)) < lane_rdy_pct);
    end
    out_tready = (int'($urandom_range(99)) < out_rdy_pct);
    #1;
    acc = 0;
    if (ce_rst) begin
      check("rst_in_tready", in_tready, 0);
      check("rst_lane_i_tvalid", lane_i_tvalid, 0);
      check("rst_lane_o_tready", lane_o_tready, 0);
      check("rst_out_tvalid", out_tvalid, 0);
      model_reset();
    end else begin
      r       = m_busy ? m_sel : first_en(m_dptr, lane_en);
      ok      = m_busy || (lane_en != 0 && m_order.size() < DEPTH);
      exp_rdy = ok && lane_i_tready[r];
      exp_lv  = (ok && in_tvalid) ? N'(1 << r) : '0;
      head    = (m_order.size() > 0) ? m_order[0] : -1;
      exp_ov  = (head >= 0) && lane_o_tvalid[head];
      exp_lor = (head >= 0 && out_tready) ? N'(1 << head) : '0;
      check("in_tready", in_tready, exp_rdy);
      check("lane_i_tvalid", lane_i_tvalid, exp_lv);
      check("lane_o_tready", lane_o_tready, exp_lor);
      check("out_tvalid", out_tvalid, exp_ov);
      check("inflight", inflight, m_order.size());
      check("pkt_in_cnt", pkt_in_cnt, m_in_cnt);
      check("pkt_out_cnt", pkt_out_cnt, m_out_cnt);
      if (in_tvalid)
        for (int k = 0; k < N; k++) check("lane_i_tdata", lane_i_tdata[k*W +: W], in_tdata);
      if (head >= 0) check("out_tuser", out_tuser, m_hdr_q[0]);
      if (exp_ov && exp_q.size() > 0) begin
        check("out_tdata", out_tdata, exp_q[0].d);
        check("out_tlast", out_tlast, exp_q[0].l);
      end
      for (int k = 0; k < N; k++)
        if (lane_i_tvalid[k] && lane_i_tready[k]) begin
          if (!obs_busy) begin obs_busy = 1; obs_first = k; end
          if (in_tlast) begin obs_busy = 0; obs_last = k; obs_pkts[k]++; obs_lanes.push_back(k); end
        end
      if (lane_o_tvalid[1] && !lane_o_tready[1]) t2_held++;
      if (exp_ov && out_tready && exp_q.size() > 0) begin
        void'(lq_d[head].pop_front()); void'(lq_l[head].pop_front()); void'(lq_t[head].pop_front());
        b = exp_q.pop_front();
        if (b.l) begin
          void'(m_order.pop_front()); void'(m_hdr_q.pop_front()); m_out_cnt++;
        end
      end
      if (in_tvalid && exp_rdy) begin
        acc = 1;
        if (!m_busy) begin
          m_busy = 1; m_sel = r; m_order.push_back(r); m_hdr_q.push_back(in_tuser);
        end
        lq_d[r].push_back(in_tdata); lq_l[r].push_back(in_tlast); lq_t[r].push_back(cyc + lat[r]);
        b.d = in_tdata; b.l = in_tlast;
        exp_q.push_back(b);
        if (in_tlast) begin m_busy = 0; m_dptr = (r + 1) % N; m_in_cnt++; end
      end
      if (clear_cnt) begin m_in_cnt = 0; m_out_cnt = 0; end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic send_packet(input logic [H-1:0] hdr, input int n, input int bubble_pct, input bit clr_last,
                             input int switch_at, input logic [N-1:0] switch_en);
    bit acc;
    int guard;
    for (int b = 0; b < n; b++) begin
      if (int'($urandom_range(99)) < bubble_pct) begin in_tvalid = 0; cycle(acc); end
      if (b == switch_at) lane_en = switch_en;
      in_tvalid = 1;
      in_tdata  = $urandom;
      in_tlast  = (b == n - 1);
      in_tuser  = (b == 0) ? hdr : {$urandom, $urandom, $urandom, $urandom};
      clear_cnt = clr_last && (b == n - 1);
      guard = 0; acc = 0;
      while (!acc && guard < 500) begin cycle(acc); guard++; end
      check("send_accept", acc, 1'b1);
    end
    in_tvalid = 0; in_tlast = 0; clear_cnt = 0;
  endtask

  task automatic drain();
    bit acc;
    int guard = 0;
    in_tvalid = 0;
    while (m_order.size() > 0 && guard < 3000) begin cycle(acc); guard++; end
    check("drain_done", m_order.size(), 0);
  endtask

  task automatic do_reset();
    bit acc;
    ce_rst = 1; in_tvalid = 0;
    repeat (3) cycle(acc);
    ce_rst = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit   acc;
    int   exp_lanes [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [N-1:0] e;
    ce_rst = 1; lane_en = 4'hF; clear_cnt = 0;
    in_tdata = '0; in_tuser = '0; in_tlast = 0; in_tvalid = 0;
    lane_i_tready = '0; lane_o_tdata = '0; lane_o_tlast = '0; lane_o_tvalid = '0; out_tready = 0;
    for (int k = 0; k < N; k++) lat[k] = 5;
    lane_rdy_pct = 100; out_rdy_pct = 100;
    model_reset();
    do_reset();
    check("reset_inflight", inflight, 0);
    check("reset_pkt_in_cnt", pkt_in_cnt, 0);
    check("reset_pkt_out_cnt", pkt_out_cnt, 0);

    // Test 1: 8 packets of 16 beats round-robin across all lanes.
    for (int k = 0; k < N; k++) obs_pkts[k] = 0;
    obs_lanes.delete();
    for (int p = 0; p < 8; p++) send_packet(H'(p), 16, 0, 0, -1, '0);
    drain();
    check("t1_pkt_count", obs_lanes.size(), 8);
    for (int i = 0; i < 8 && i < obs_lanes.size(); i++) check("t1_lane_seq", obs_lanes[i], exp_lanes[i]);
    for (int k = 0; k < N; k++) check("t1_lane_pkts", obs_pkts[k], 2);
    check("t1_pkt_in_cnt", pkt_in_cnt, 8);
    check("t1_pkt_out_cnt", pkt_out_cnt, 8);

    // Test 2: slow lane 0 must hold back later packets on faster lanes.
    lat[0] = 100; lat[1] = 5; lat[2] = 5; lat[3] = 5;
    t2_held = 0;
    for (int p = 0; p < 4; p++) send_packet(H'(16 + p), 8, 0, 0, -1, '0);
    drain();
    check("t2_lane1_held", t2_held > 0, 1'b1);

    // Test 3: lane_en change mid-packet takes effect only at the next packet start.
    for (int k = 0; k < N; k++) lat[k] = 3;
    do_reset();
    lane_en = 4'b0101;
    send_packet(H'(32), 8, 0, 0, 3, 4'b0010);
    check("t3_first_lane", obs_first, 0);
    check("t3_last_lane", obs_last, 0);
    send_packet(H'(33), 4, 0, 0, -1, '0);
    check("t3_next_lane", obs_last, 1);
    drain();

    // Test 4: order FIFO full with output stalled, then release.
    lane_en = 4'hF; lat = '{2, 2, 2, 2}; out_rdy_pct = 0;
    clear_cnt = 1; cycle(acc); clear_cnt = 0;
    for (int p = 0; p < 4; p++) send_packet(H'(48 + p), 3, 0, 0, -1, '0);
    in_tvalid = 1; in_tuser = H'(52); in_tdata = $urandom; in_tlast = 0;
    #1;
    check("t4_inflight_full", inflight, 4);
    check("t4_in_tready_full", in_tready, 0);
    repeat (3) cycle(acc);
    check("t4_stalled", acc, 1'b0);
    out_rdy_pct = 100;
    send_packet(H'(52), 3, 0, 0, -1, '0);
    drain();
    check("t4_pkt_in_cnt", pkt_in_cnt, 5);
    check("t4_pkt_out_cnt", pkt_out_cnt, 5);

    // Test 5: single-beat packets with random stalls and enable masks.
    for (int k = 0; k < N; k++) lat[k] = 1 + int'($urandom_range(3));
    lane_rdy_pct = 70; out_rdy_pct = 60;
    for (int p = 0; p < 150; p++) begin
      do e = N'($urandom_range(15)); while (e == 0);
      lane_en = e;
      send_packet(H'(100 + p), 1, 30, 0, -1, '0);
    end
    drain();
    check("t5_pkt_in_cnt", pkt_in_cnt, 155);
    check("t5_pkt_out_cnt", pkt_out_cnt, 155);

    // Test 6: reset mid-packet, then clear_cnt coinciding with a tlast.
    lane_en = 4'hF; lane_rdy_pct = 100; out_rdy_pct = 100; lat = '{3, 3, 3, 3};
    in_tvalid = 1; in_tlast = 0; in_tuser = H'(64);
    for (int b = 0; b < 3; b++) begin in_tdata = $urandom; cycle(acc); end
    do_reset();
    check("t6_rst_pkt_in_cnt", pkt_in_cnt, 0);
    check("t6_rst_pkt_out_cnt", pkt_out_cnt, 0);
    check("t6_rst_inflight", inflight, 0);
    send_packet(H'(65), 4, 0, 1, -1, '0);
    check("t6_clear_wins_in", pkt_in_cnt, 0);
    check("t6_clear_out", pkt_out_cnt, 0);
    drain();
    check("t6_out_after", pkt_out_cnt, 1);
    check("t6_in_after", pkt_in_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
